// File: rtl/tt_um_aditya_patra.sv
// Eight-channel sensor-to-buzzer alarm controller.
// Each channel debounces its sensor and plays a 4-cycle square tone with cooldown.
module alarm_chan #(
  parameter int COOL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic sense,
  output logic buzz
);

  localparam int CW = (COOL > 1) ? $clog2(COOL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ALARM,
    COOLDOWN
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [1:0]    phase;
  logic [1:0]    phase_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          buzz_d;

  always_comb begin
    state_d = state;
    phase_d = phase;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (sense) state_d = ARM;
      end
      ARM: begin
        phase_d = 2'd0;
        state_d = sense ? ALARM : IDLE;
      end
      ALARM: begin
        phase_d = phase + 2'd1;
        if (!sense) begin
          state_d = COOLDOWN;
          cnt_d   = CW'(COOL - 1);
        end
      end
      COOLDOWN: begin
        phase_d = phase + 2'd1;
        if (sense) begin
          // re-trigger keeps the running tone phase
          state_d = ALARM;
        end else if (cnt == '0) begin
          state_d = IDLE;
          phase_d = 2'd0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 2'd0;
        cnt_d   = '0;
      end
    endcase
    if (!ena) begin
      state_d = IDLE;
      phase_d = 2'd0;
      cnt_d   = '0;
    end
    buzz_d = ((state_d == ALARM) || (state_d == COOLDOWN))
             && !phase_d[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= 2'd0;
      cnt   <= '0;
      buzz  <= 1'b0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      cnt   <= cnt_d;
      buzz  <= buzz_d;
    end
  end

endmodule

module tt_um_aditya_patra #(
  parameter int NCH  = 8,
  parameter int COOL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    alarm_chan #(
      .COOL(COOL)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .sense(ui_in[i]),
      .buzz (uo_out[i])
    );
  end

endmodule

// File: tb/tb_tt_um_aditya_patra.sv
// Scoreboard bench for the eight-channel alarm controller.
// A behavioural channel model queues expected outputs per edge.
module tb_tt_um_aditya_patra;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  int m_st[8];
  int m_ph[8];
  int m_cnt[8];

  always #5 clk = ~clk;

  tt_um_aditya_patra dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // model: 0 idle, 1 arm, 2 alarm, 3 cooldown
  function automatic logic [7:0] model_edge(
    input logic [7:0] ui, input logic en, input logic rn);
    logic [7:0] o;
    o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (!rn || !en) begin
        m_st[i] = 0; m_ph[i] = 0; m_cnt[i] = 0;
      end else begin
        case (m_st[i])
          0: if (ui[i]) m_st[i] = 1;
          1: begin
            if (ui[i]) begin m_st[i] = 2; m_ph[i] = 0; end
            else m_st[i] = 0;
          end
          2: begin
            m_ph[i] = (m_ph[i] + 1) % 4;
            if (!ui[i]) begin m_st[i] = 3; m_cnt[i] = 3; end
          end
          default: begin
            m_ph[i] = (m_ph[i] + 1) % 4;
            if (ui[i]) m_st[i] = 2;
            else if (m_cnt[i] == 0) begin m_st[i] = 0; m_ph[i] = 0; end
            else m_cnt[i] = m_cnt[i] - 1;
          end
        endcase
      end
      o[i] = (m_st[i] >= 2) && (m_ph[i] < 2);
    end
    return o;
  endfunction

  task automatic step(input logic [7:0] ui, input logic en,
                      input logic rn, output logic [7:0] got);
    logic [7:0] e;
    ui_in = ui; ena = en; rst_n = rn;
    uio_in = 8'($urandom);
    exp_q.push_back(model_edge(ui, en, rn));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got = uo_out;
    checks++;
    if (uo_out !== e) begin
      errors++;
      $display("FAIL uo_out got %h exp %h ui %h ena %b rst_n %b",
               uo_out, e, ui, en, rn);
    end
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++;
      $display("FAIL uio got out %h oe %h exp 00 00", uio_out, uio_oe);
    end
  endtask

  task automatic test_reset();
    logic [7:0] g;
    step(8'hFF, 1'b1, 1'b0, g);
    step(8'h00, 1'b1, 1'b1, g);
    step(8'h00, 1'b1, 1'b1, g);
  endtask

  task automatic test_single();
    logic [7:0] g;
    logic [7:0] pat[15];
    pat = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01,
            8'h00, 8'h00, 8'h01,
            8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 15; i++) begin
      step((i < 10) ? 8'h01 : 8'h00, 1'b1, 1'b1, g);
      checks++;
      if (g !== pat[i]) begin
        errors++;
        $display("FAIL single[%0d] got %h exp %h", i, g, pat[i]);
      end
    end
    step(8'h00, 1'b1, 1'b1, g);
  endtask

  task automatic test_glitch();
    logic [7:0] g;
    step(8'h02, 1'b1, 1'b1, g);
    for (int i = 0; i < 6; i++) begin
      step(8'h00, 1'b1, 1'b1, g);
      checks++;
      if (g !== 8'h00) begin
        errors++;
        $display("FAIL glitch[%0d] got %h exp 00", i, g);
      end
    end
  endtask

  task automatic test_pair();
    logic [7:0] g;
    for (int i = 0; i < 40; i++) step(8'h06, 1'b1, 1'b1, g);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b1, g);
    checks++;
    if (g !== 8'h00) begin
      errors++;
      $display("FAIL pair_release got %h exp 00", g);
    end
  endtask

  task automatic test_all_ena();
    logic [7:0] g;
    for (int i = 0; i < 20; i++) begin
      step(8'hFF, 1'b1, 1'b1, g);
      if (i >= 1) begin
        checks++;
        if (g !== (((i - 1) % 4) < 2 ? 8'hFF : 8'h00)) begin
          errors++;
          $display("FAIL all[%0d] got %h", i, g);
        end
      end
    end
    step(8'hFF, 1'b0, 1'b1, g);
    checks++;
    if (g !== 8'h00) begin
      errors++;
      $display("FAIL ena_off got %h exp 00", g);
    end
    for (int i = 0; i < 6; i++) step(8'hFF, 1'b1, 1'b1, g);
    step(8'hFF, 1'b1, 1'b0, g);
    for (int i = 0; i < 4; i++) step(8'hFF, 1'b1, 1'b1, g);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b1, g);
  endtask

  task automatic test_retrigger();
    logic [7:0] g;
    logic [7:0] pat[11];
    logic [7:0] ui;
    pat = '{8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04,
            8'h04, 8'h00, 8'h00, 8'h04, 8'h04};
    for (int i = 0; i < 11; i++) begin
      ui = (i == 6 || i == 7) ? 8'h00 : 8'h04;
      step(ui, 1'b1, 1'b1, g);
      checks++;
      if (g !== pat[i]) begin
        errors++;
        $display("FAIL retrig[%0d] got %h exp %h", i, g, pat[i]);
      end
    end
    for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b1, g);
  endtask

  task automatic test_random();
    logic [7:0] g;
    for (int i = 0; i < 300; i++)
      step(8'($urandom), ($urandom_range(0, 31) != 0),
           ($urandom_range(0, 63) != 0), g);
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_pair();
    test_all_ena();
    test_retrigger();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
